// File: rtl/breath_envelope.sv
// Breathing duty-cycle generator for the pwm block: ramp up, hold at full scale,
// ramp down, hold at zero, repeating while enabled.
module breath_envelope #(
  parameter int PWM_BITS   = 8,
  parameter int STEP_DIV   = 300000,
  parameter int DIV_BITS   = 20,
  parameter int HOLD_STEPS = 16
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_enable,
  input  logic [PWM_BITS-1:0] i_step,
  output logic [PWM_BITS-1:0] o_duty_cycle,
  output logic                o_duty_valid,
  output logic                o_cycle_done,
  output logic                o_busy
);

  localparam int HOLD_BITS = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [PWM_BITS-1:0]  DUTY_MAX  = {PWM_BITS{1'b1}};
  localparam logic [DIV_BITS-1:0]  DIV_LAST  = DIV_BITS'(STEP_DIV - 1);
  localparam logic [DIV_BITS-1:0]  DIV_PRE   = DIV_BITS'(STEP_DIV - 2);
  localparam logic [HOLD_BITS-1:0] HOLD_LAST = HOLD_BITS'(HOLD_STEPS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RISE    = 3'd1,
    ST_HOLD_HI = 3'd2,
    ST_FALL    = 3'd3,
    ST_HOLD_LO = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [DIV_BITS-1:0]  presc_q, presc_d;
  logic [HOLD_BITS-1:0] hold_q, hold_d;
  logic [PWM_BITS-1:0]  duty_q, duty_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic                tick_s;
  logic                pre_tick_s;
  logic [PWM_BITS-1:0] step_s;
  logic [PWM_BITS:0]   sum_s;

  // pre_tick_s lets o_cycle_done be registered yet still land in the final tick cycle
  assign tick_s     = (state_q != ST_IDLE) && (presc_q == DIV_LAST);
  assign pre_tick_s = (state_q != ST_IDLE) && (presc_q == DIV_PRE);
  assign step_s     = (i_step == '0) ? PWM_BITS'(1) : i_step;
  assign sum_s      = {1'b0, duty_q} + {1'b0, step_s};

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    hold_d  = hold_q;
    duty_d  = duty_q;
    done_d  = 1'b0;

    if (state_q == ST_IDLE || tick_s) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + DIV_BITS'(1);
    end

    case (state_q)
      ST_IDLE: begin
        duty_d  = '0;
        hold_d  = '0;
        state_d = i_enable ? ST_RISE : ST_IDLE;
      end
      ST_RISE: begin
        if (tick_s && (sum_s >= {1'b0, DUTY_MAX})) begin
          duty_d  = DUTY_MAX;
          hold_d  = '0;
          state_d = ST_HOLD_HI;
        end else if (tick_s) begin
          duty_d = sum_s[PWM_BITS-1:0];
        end else begin
          duty_d = duty_q;
        end
      end
      ST_HOLD_HI: begin
        if (tick_s && (hold_q == HOLD_LAST)) begin
          state_d = ST_FALL;
        end else if (tick_s) begin
          hold_d = hold_q + HOLD_BITS'(1);
        end else begin
          hold_d = hold_q;
        end
      end
      ST_FALL: begin
        if (tick_s && (duty_q <= step_s)) begin
          duty_d  = '0;
          hold_d  = '0;
          state_d = ST_HOLD_LO;
        end else if (tick_s) begin
          duty_d = duty_q - step_s;
        end else begin
          duty_d = duty_q;
        end
      end
      ST_HOLD_LO: begin
        done_d = pre_tick_s && (hold_q == HOLD_LAST);
        if (tick_s && (hold_q == HOLD_LAST)) begin
          state_d = i_enable ? ST_RISE : ST_IDLE;
        end else if (tick_s) begin
          hold_d = hold_q + HOLD_BITS'(1);
        end else begin
          hold_d = hold_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        duty_d  = '0;
        hold_d  = '0;
      end
    endcase

    valid_d = (duty_d != duty_q);
    busy_d  = (state_d != ST_IDLE);
  end

  // State, counters and registered outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      hold_q  <= '0;
      duty_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
      duty_q  <= duty_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign o_duty_cycle = duty_q;
  assign o_duty_valid = valid_q;
  assign o_cycle_done = done_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_breath_envelope.sv
// Randomised and directed bench for breath_envelope against a per-cycle
// behavioural envelope model.
module tb_breath_envelope;

  localparam int PW   = 8;
  localparam int SD   = 4;
  localparam int HS   = 2;
  localparam int MAXV = 255;
  localparam int UP = 0, TOP = 1, DOWN = 2, BOTTOM = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [PW-1:0] step;
  logic [PW-1:0] o_duty_cycle;
  logic          o_duty_valid;
  logic          o_cycle_done;
  logic          o_busy;

  breath_envelope #(.PWM_BITS(PW), .STEP_DIV(SD), .DIV_BITS(20), .HOLD_STEPS(HS)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_step(step),
    .o_duty_cycle(o_duty_cycle), .o_duty_valid(o_duty_valid),
    .o_cycle_done(o_cycle_done), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_run, m_div, m_phase, m_hold, m_duty, m_valid;
  int n_valid, n_done, cyc;
  int vq[$];
  int vcyc[$];
  int exp64[8] = '{64, 128, 192, 255, 191, 127, 63, 0};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_div = 0; m_phase = UP; m_hold = 0; m_duty = 0; m_valid = 0;
  endtask

  // Advance the envelope model across one rising edge using current inputs
  task automatic model_edge();
    int st, nd;
    m_valid = 0;
    st = (step == 0) ? 1 : int'(step);
    nd = m_duty;
    if (m_run == 0) begin
      if (en) begin
        m_run = 1; m_div = 0; m_phase = UP; m_hold = 0;
      end
    end else if (m_div != SD - 1) begin
      m_div++;
    end else begin
      m_div = 0;
      case (m_phase)
        UP: begin
          nd = m_duty + st;
          if (nd >= MAXV) begin nd = MAXV; m_phase = TOP; m_hold = 0; end
        end
        TOP: if (m_hold == HS - 1) m_phase = DOWN; else m_hold++;
        DOWN: begin
          if (m_duty <= st) begin nd = 0; m_phase = BOTTOM; m_hold = 0; end
          else nd = m_duty - st;
        end
        default: begin
          if (m_hold != HS - 1) m_hold++;
          else if (en) m_phase = UP;
          else m_run = 0;
        end
      endcase
      m_valid = (nd != m_duty);
      m_duty = nd;
    end
  endtask

  task automatic check_all(input string tag);
    int e_done;
    e_done = (m_run != 0 && m_phase == BOTTOM && m_hold == HS - 1 && m_div == SD - 1) ? 1 : 0;
    check_val({tag, "_duty"}, o_duty_cycle, m_duty);
    check_val({tag, "_valid"}, o_duty_valid, m_valid);
    check_val({tag, "_done"}, o_cycle_done, e_done);
    check_val({tag, "_busy"}, o_busy, m_run);
  endtask

  task automatic cycle();
    if (rst_n) model_edge(); else model_reset();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_all("cyc");
    if (o_duty_valid === 1'b1) begin
      n_valid++;
      vq.push_back(int'(o_duty_cycle));
      vcyc.push_back(cyc);
    end
    if (o_cycle_done === 1'b1) n_done++;
  endtask

  task automatic clear_log();
    n_valid = 0; n_done = 0; vq.delete(); vcyc.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; step = '0;
    repeat (2) cycle();
    rst_n = 1'b1;
    clear_log();
  endtask

  task automatic check_breath64(input string tag);
    check_val({tag, "_nvalid"}, vq.size(), 8);
    check_val({tag, "_ndone"}, n_done, 1);
    if (vq.size() == 8) begin
      for (int i = 0; i < 8; i++) check_val({tag, "_seq"}, vq[i], exp64[i]);
      for (int i = 1; i < 8; i++)
        if (i != 4) check_val({tag, "_gap"}, vcyc[i] - vcyc[i-1], SD);
    end
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; en = 1'b0; step = '0; cyc = 0;
    model_reset();
    clear_log();
    @(negedge clk);
    check_all("reset");
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (50) cycle();
    check_val("idle_nvalid", n_valid, 0);
    check_val("idle_ndone", n_done, 0);

    // Full breath at step 64, then immediate restart
    do_reset();
    en = 1'b1; step = 8'd64;
    repeat (48) cycle();
    check_breath64("s2");
    cycle();
    check_val("s2_restart_busy", o_busy, 1);

    // Step extremes
    do_reset();
    en = 1'b1; step = 8'd255;
    repeat (24) cycle();
    check_val("s3a_nvalid", vq.size(), 2);
    check_val("s3a_ndone", n_done, 1);
    if (vq.size() == 2) begin
      check_val("s3a_top", vq[0], 255);
      check_val("s3a_bot", vq[1], 0);
    end
    do_reset();
    en = 1'b1; step = 8'd0;
    repeat (SD * (255 + HS + 255 + HS)) cycle();
    check_val("s3b_nvalid", vq.size(), 510);
    check_val("s3b_ndone", n_done, 1);
    if (vq.size() == 510) begin
      check_val("s3b_first", vq[0], 1);
      check_val("s3b_peak", vq[254], 255);
      check_val("s3b_last", vq[509], 0);
    end

    // Graceful stop requested during the fall
    do_reset();
    en = 1'b1; step = 8'd64;
    repeat (30) cycle();
    en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle();
      if (o_cycle_done === 1'b1) found = 1'b1;
    end
    check_val("s4_done_seen", found, 1);
    check_val("s4_busy_at_done", o_busy, 1);
    cycle();
    check_val("s4_busy_off", o_busy, 0);
    repeat (20) cycle();
    check_val("s4_duty_zero", o_duty_cycle, 0);
    check_val("s4_nvalid", vq.size(), 8);

    // Asynchronous reset between edges mid-rise
    do_reset();
    en = 1'b1; step = 8'd64;
    repeat (6) cycle();
    check_val("s5_pre_duty", o_duty_cycle, 64);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check_val("s5_async_duty", o_duty_cycle, 0);
    check_all("s5_async");
    repeat (2) cycle();
    rst_n = 1'b1;
    clear_log();
    repeat (48) cycle();
    check_breath64("s5");

    // Step change mid-rise
    do_reset();
    en = 1'b1; step = 8'd16;
    repeat (9) cycle();
    check_val("s6_before", o_duty_cycle, 32);
    step = 8'd32;
    clear_log();
    repeat (4) cycle();
    check_val("s6_nvalid", n_valid, 1);
    check_val("s6_after", o_duty_cycle, 64);
    repeat (4) cycle();
    check_val("s6_next", o_duty_cycle, 96);

    // Random enable/step traffic with occasional asynchronous resets
    do_reset();
    repeat (800) begin
      en = ($urandom_range(0, 9) != 0);
      step = PW'($urandom_range(0, 255));
      if ($urandom_range(0, 299) == 0) begin
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_all("rnd_async");
        cycle();
        rst_n = 1'b1;
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
